// File: rtl/read_arbiter.sv
// Two-requester read arbiter onto one downstream read port, one read in flight.
// Define READ_ARBITER_ROUND_ROBIN_EN for round-robin; default is s1-first priority.
module read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [2:0]            s0_arprot,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [2:0]            s1_arprot,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic                  win;
    logic                  accept;
    logic                  in_data;

`ifdef READ_ARBITER_ROUND_ROBIN_EN
    // last_q holds the most recent winner; reset value 1 lets s0 win first
    logic last_q, last_d;

    assign win    = (s0_arvalid & s1_arvalid) ? ~last_q : s1_arvalid;
    assign last_d = accept ? win : last_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = s1_arvalid;
`endif

    // aresetn gate keeps arready low while reset is held
    assign accept  = (state_q == IDLE) & (s0_arvalid | s1_arvalid) & aresetn;
    assign in_data = (state_q == DATA);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        prot_d  = prot_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR;
                    grant_d = win;
                    addr_d  = win ? s1_araddr : s0_araddr;
                    prot_d  = win ? s1_arprot : s0_arprot;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_rvalid & m_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            addr_q  <= '0;
            prot_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            prot_q  <= prot_d;
        end
    end

    assign s0_arready = accept & ~win;
    assign s1_arready = accept & win;

    assign m_araddr  = addr_q;
    assign m_arprot  = prot_q;
    assign m_arvalid = (state_q == ADDR);

    assign m_rready  = in_data & (grant_q ? s1_rready : s0_rready);

    assign s0_rvalid = in_data & ~grant_q & m_rvalid;
    assign s1_rvalid = in_data & grant_q & m_rvalid;
    assign s0_rdata  = (in_data & ~grant_q) ? m_rdata : '0;
    assign s1_rdata  = (in_data & grant_q) ? m_rdata : '0;
    assign s0_rresp  = (in_data & ~grant_q) ? m_rresp : '0;
    assign s1_rresp  = (in_data & grant_q) ? m_rresp : '0;

endmodule

// File: tb/tb_read_arbiter.sv
// Directed bench for read_arbiter: scoreboard of expected grants and read data.
// Define READ_ARBITER_ROUND_ROBIN_EN here too when building the round-robin variant.
module tb_read_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s0_araddr, s1_araddr;
    logic [2:0]  s0_arprot, s1_arprot;
    logic        s0_arvalid, s1_arvalid;
    logic        s0_arready, s1_arready;
    logic [31:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        s0_rvalid, s1_rvalid;
    logic        s0_rready, s1_rready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid, m_rready;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arprot(s1_arprot),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge aclk);
        #1;
    endtask

    // One complete read: request, address phase, data phase, completion.
    task automatic do_req(input bit v0, input bit v1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input bit ep, input logic [31:0] data,
                          input int ar_wait, input int r_stall,
                          input bit hold);
        exp_t e;
        exp_t got;
        e.port = ep;
        e.addr = ep ? a1 : a0;
        e.data = data;
        sb.push_back(e);
        s0_araddr  = a0;
        s0_arprot  = a0[6:4];
        s1_araddr  = a1;
        s1_arprot  = a1[6:4];
        s0_arvalid = v0;
        s1_arvalid = v1;
        @(negedge aclk);
        chk("arready_s0", s0_arready, !ep);
        chk("arready_s1", s1_arready, ep);
        chk("idle_arvalid", m_arvalid, 1'b0);
        next_cyc();
        if (!hold) begin
            s0_arvalid = 1'b0;
            s1_arvalid = 1'b0;
        end
        m_arready = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge aclk);
            chk("wait_arvalid", m_arvalid, 1'b1);
            chk("wait_araddr", m_araddr, sb[0].addr);
            chk("wait_arready", {s0_arready, s1_arready}, 2'b00);
            next_cyc();
        end
        m_arready = 1'b1;
        @(negedge aclk);
        chk("m_arvalid", m_arvalid, 1'b1);
        chk("m_araddr", m_araddr, sb[0].addr);
        chk("m_arprot", m_arprot, sb[0].addr[6:4]);
        chk("addr_rvalid", {s0_rvalid, s1_rvalid, m_rready}, 3'b000);
        next_cyc();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = data;
        m_rresp   = data[1:0];
        s0_rready = 1'b0;
        s1_rready = 1'b0;
        for (int i = 0; i < r_stall; i++) begin
            @(negedge aclk);
            chk("stall_rready", m_rready, 1'b0);
            chk("stall_rvalid", {s1_rvalid, s0_rvalid},
                ep ? 2'b10 : 2'b01);
            chk("stall_arvalid", m_arvalid, 1'b0);
            next_cyc();
        end
        if (ep) s1_rready = 1'b1;
        else    s0_rready = 1'b1;
        @(negedge aclk);
        chk("m_rready", m_rready, 1'b1);
        chk("data_arready", {s0_arready, s1_arready}, 2'b00);
        if (s0_rvalid | s1_rvalid) begin
            got = sb.pop_front();
            chk("rvalid_port", s1_rvalid, got.port);
            chk("rvalid_other", got.port ? s0_rvalid : s1_rvalid, 1'b0);
            chk("rdata", got.port ? s1_rdata : s0_rdata, got.data);
            chk("rresp", got.port ? s1_rresp : s0_rresp, got.data[1:0]);
        end else begin
            chk("rvalid_none", {s0_rvalid, s1_rvalid}, ep ? 2'b10 : 2'b01);
            sb.delete();
        end
        next_cyc();
        m_rvalid  = 1'b0;
        s0_rready = 1'b0;
        s1_rready = 1'b0;
        chk("done_idle", {m_arvalid, m_rready}, 2'b00);
    endtask

    bit ord[4];

    initial begin
`ifdef READ_ARBITER_ROUND_ROBIN_EN
        ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        aresetn    = 1'b0;
        s0_araddr  = 32'h0;
        s1_araddr  = 32'h0;
        s0_arprot  = 3'h0;
        s1_arprot  = 3'h0;
        s0_arvalid = 1'b1;
        s1_arvalid = 1'b1;
        s0_rready  = 1'b1;
        s1_rready  = 1'b1;
        m_arready  = 1'b0;
        m_rdata    = 32'h0;
        m_rresp    = 2'b00;
        m_rvalid   = 1'b1;

        // reset state with requests and data pending
        #2;
        chk("rst_arready", {s0_arready, s1_arready}, 2'b00);
        chk("rst_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
        chk("rst_m", {m_arvalid, m_rready}, 2'b00);
        chk("rst_addr", {m_araddr, 1'b0, m_arprot}, 36'h0);
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        m_rvalid   = 1'b0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;
        next_cyc();
        aresetn = 1'b1;
        next_cyc();

        // lone s0 fetch, zero wait
        do_req(1, 0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 0, 0, 0);

        // withdrawn request leaves the arbiter idle
        s1_arvalid = 1'b1;
        s1_araddr  = 32'h0000_0777;
        @(negedge aclk);
        chk("wd_arready", s1_arready, 1'b1);
        #1;
        s1_arvalid = 1'b0;
        next_cyc();
        chk("wd_idle", {m_arvalid, m_rready}, 2'b00);
        next_cyc();
        chk("wd_idle2", m_arvalid, 1'b0);

        // address stall of 5 cycles
        do_req(0, 1, 32'h0, 32'h0000_0A40, 1, 32'h1234_5679, 5, 0, 0);

        // s1 data stall of 3 cycles
        do_req(0, 1, 32'h0, 32'h0000_0B50, 1, 32'hCAFE_F00E, 0, 3, 0);

        // fresh reset, then both ports request continuously
        aresetn = 1'b0;
        next_cyc();
        aresetn = 1'b1;
        next_cyc();
        for (int k = 0; k < 4; k++) begin
            do_req(1, 1, 32'h0000_1000 + 32'(k * 16),
                   32'h0000_2000 + 32'(k * 16), ord[k],
                   32'hA5A5_0000 + 32'(k), 0, 0, 1);
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        next_cyc();

        // reset asserted during the address phase
        s0_araddr  = 32'h0000_0300;
        s0_arprot  = 3'h5;
        s0_arvalid = 1'b1;
        @(negedge aclk);
        chk("ra_arready", s0_arready, 1'b1);
        next_cyc();
        s0_arvalid = 1'b0;
        chk("ra_addr_phase", m_arvalid, 1'b1);
        #2;
        aresetn    = 1'b0;
        s1_arvalid = 1'b1;
        #1;
        chk("ra_m", {m_arvalid, m_rready}, 2'b00);
        chk("ra_arready2", {s0_arready, s1_arready}, 2'b00);
        chk("ra_addr", {m_araddr, 1'b0, m_arprot}, 36'h0);
        chk("ra_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
        next_cyc();
        s1_arvalid = 1'b0;
        aresetn    = 1'b1;
        m_rvalid   = 1'b1;
        m_rdata    = 32'hBAD0_BAD0;
        s0_rready  = 1'b1;
        @(negedge aclk);
        chk("late_rready", m_rready, 1'b0);
        chk("late_rvalid", {s0_rvalid, s1_rvalid}, 2'b00);
        next_cyc();
        m_rvalid  = 1'b0;
        s0_rready = 1'b0;
        chk("late_idle", m_arvalid, 1'b0);
        do_req(1, 0, 32'h0000_0400, 32'h0, 0, 32'h0BAD_F00D, 1, 1, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_arbiter.md
READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of every ar channel.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of every r channel.
REQ-003 SHALL have port aclk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports s0_araddr/s1_araddr, input, ADDR_WIDTH: requester read address (s0 = fetch, s1 = load).
REQ-006 SHALL have ports s0_arprot/s1_arprot, input, 3: requester protection bits.
REQ-007 SHALL have ports s0_arvalid/s1_arvalid, input, 1: requester address valid.
REQ-008 SHALL have ports s0_arready/s1_arready, output, 1: requester address accepted.
REQ-009 SHALL have ports s0_rdata/s1_rdata, output, DATA_WIDTH: returned read data.
REQ-010 SHALL have ports s0_rresp/s1_rresp, output, 2: returned response.
REQ-011 SHALL have ports s0_rvalid/s1_rvalid, output, 1: returned data valid.
REQ-012 SHALL have ports s0_rready/s1_rready, input, 1: requester data ready.
REQ-013 SHALL have ports m_araddr (output, ADDR_WIDTH), m_arprot (output, 3), m_arvalid (output, 1) and m_arready (input, 1): shared downstream address channel.
REQ-014 SHALL have ports m_rdata (input, DATA_WIDTH), m_rresp (input, 2), m_rvalid (input, 1) and m_rready (output, 1): shared downstream data channel.

Function
REQ-015 SHALL implement the states IDLE, ADDR and DATA, with at most one outstanding downstream read.
REQ-016 In IDLE with any sN_arvalid high, SHALL select one winner per REQ-029/030, assert the winner's sN_arready combinationally in the same cycle, and hold the loser's arready low.
REQ-017 On acceptance SHALL register araddr/arprot into m_araddr/m_arprot, latch the grant, and enter ADDR; m_arvalid SHALL be high exactly one cycle after acceptance.
REQ-018 In ADDR SHALL hold m_arvalid and m_araddr stable until m_arvalid & m_arready, then enter DATA with m_arvalid low on the next cycle.
REQ-019 In DATA SHALL route m_rdata/m_rresp/m_rvalid to the granted port and drive m_rready = granted sN_rready; the non-granted sN_rvalid SHALL be 0.
REQ-020 On m_rvalid & m_rready SHALL return to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-021 All sN_arready SHALL be 0 in ADDR and DATA; no sN_rvalid or m_rready SHALL be high outside DATA.
REQ-022 A request withdrawn before acceptance SHALL leave the state unchanged.
REQ-023 Minimum request-to-m_arvalid latency SHALL be 1 cycle; minimum back-to-back issue period SHALL be 3 cycles.

Reset
REQ-024 Assertion of aresetn low SHALL immediately force IDLE, regardless of the current state.
REQ-025 During reset SHALL drive m_arvalid=0, m_rready=0, all sN_arready=0, all sN_rvalid=0, m_araddr=0, m_arprot=0 and grant=s0.
REQ-026 Reset mid-transaction SHALL abandon it; a late m_rvalid after reset release SHALL be dropped (m_rready=0 in IDLE).
REQ-027 SHALL set the round-robin pointer so that s0 wins the first simultaneous request after reset.
REQ-028 SHALL NOT require sN_arready to be asserted during reset.

Configuration
REQ-029 With macro READ_ARBITER_ROUND_ROBIN_EN defined, SHALL use round-robin arbitration: on simultaneous requests the port not granted last wins, and the pointer updates only on acceptance.
REQ-030 Without READ_ARBITER_ROUND_ROBIN_EN, SHALL use fixed priority: s1 (load) wins over s0 on simultaneous requests, with no pointer state.

Verification
REQ-031 Lone s0 request with araddr=0x0000_0100 and m_arready=1, m_rdata=0xDEAD_BEEF one cycle later -> s0_arready in cycle 0, m_arvalid in cycle 1, s0_rvalid with 0xDEAD_BEEF in cycle 2, s1_rvalid=0 throughout.
REQ-032 Both ports request continuously, 4 transactions, with the macro -> grant order s0, s1, s0, s1; without the macro -> s1, s1, s1, s1.
REQ-033 m_arready held low 5 cycles -> m_arvalid and m_araddr stable for those 5 cycles, all sN_arready=0.
REQ-034 s1 in DATA with s1_rready=0 for 3 cycles while m_rvalid=1 -> m_rready=0 and s1_rvalid=1 held; completes on the first s1_rready=1 cycle and returns to IDLE.
REQ-035 aresetn pulsed low during ADDR -> outputs match REQ-025 within the same cycle, a late m_rvalid is ignored, and the next request is serviced normally.
